nand_netlist_eval: RTL and testbench
====================================

Name: nand_netlist_eval

Overview:
- Sequential evaluator for NAND-only gate netlists, as produced by the team's NAND techmap flow. It consumes mapped netlists in hardware rather than producing them.
- The gate list (net indices a, b, y per gate) is loaded into internal gate memory. On start, the block applies primary inputs, then sweeps the gates one per cycle. It then presents selected nets as outputs.
- Net values persist between evaluations, so mapped storage such as cross-coupled NAND latches and DFF structures can be emulated.
- Used as an on-chip checker for NAND-mapped designs.

Parameters:
- NET_AW, 8: net index width; net value file has 2^NET_AW one-bit entries.
- GATE_AW, 8: gate memory address width; up to 2^GATE_AW gates.
- IN_W, 8: primary inputs; drive nets 0..IN_W-1.
- OUT_W, 8: primary outputs; taken from nets OUT_BASE..OUT_BASE+OUT_W-1.
- OUT_BASE, 16: first output net index; OUT_BASE+OUT_W <= 2^NET_AW.
- PASS_W, 4: width of the pass-count input.

Ports:
- C  in  1  clock; all state updates on rising edge.
- R  in  1  reset; synchronous and active-low.
- gate_we  in  1  gate memory write enable.
- gate_addr  in  GATE_AW  gate index to write.
- gate_a  in  NET_AW  input net A of gate.
- gate_b  in  NET_AW  input net B of gate.
- gate_y  in  NET_AW  output net of gate.
- start  in  1  one-cycle request to evaluate.
- in_vec  in  IN_W  primary input values, sampled with start.
- num_gates  in  GATE_AW+1  gates to evaluate, sampled with start.
- num_passes  in  PASS_W  sweeps over the gate list; 0 is treated as 1.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse; out_vec valid.
- out_vec  out  OUT_W  captured output nets; held until the next done.

Behaviour:
- Reset (R low at a rising edge):
  - state goes to IDLE; busy=0, done=0, out_vec=0.
  - All net values are cleared to 0.
  - Gate memory is not cleared.
  - Reset takes priority over every other input, including mid-evaluation.
- States:
  - IDLE: accepts start when R is high.
    - Captures in_vec, num_gates, and max(num_passes,1).
    - Next state is LOAD.
  - LOAD (1 cycle): writes in_vec[i] to net i for all i in parallel; clears gate counter g and pass counter p.
    - If num_gates==0, next state is DONE.
    - Otherwise next state is EVAL.
  - EVAL (1 cycle per gate):
    - Reads gate g and writes val[y] <= ~(val[a] & val[b]).
    - The next cycle's read sees this write (register-file read is combinational).
    - At g==num_gates-1: if p==passes-1, next state is DONE; otherwise g=0 and p++.
  - DONE (1 cycle):
    - out_vec <= val[OUT_BASE +: OUT_W].
    - done=1, busy=0; next state is IDLE.
- Latency: done asserts 2 + num_gates*passes cycles after the start edge.
- busy is 1 in LOAD and EVAL only.
- Gates are evaluated strictly in address order.
  - A topologically ordered list settles in one pass.
  - Feedback loops need extra passes; the result is exactly the sequential in-order evaluation.
- Gate writes:
  - Accepted in IDLE and DONE.
  - Ignored while busy.
  - A write and a start in the same IDLE cycle: the write takes effect, and the new gate is used by that run.
- start while busy or in DONE: ignored, not queued.
- A gate may write any net, including input nets; inputs are overwritten again at the next LOAD.
- a==b is a legal inverter.
- y equal to a or b is legal: read-before-write within the cycle.
- Net values other than inputs are retained across runs.
- Gate addresses >= num_gates are not evaluated.

Test Plan:
- Inverter, single gate (a=0,b=0,y=16), num_gates=1, passes=1:
  - in_vec=0x01 -> out_vec=0x00.
  - in_vec=0x00 -> out_vec=0x01.
  - done exactly 3 cycles after start.
- XOR from 4 NANDs (16=nand(0,1), 17=nand(0,16), 18=nand(1,16), 19=nand(17,18)):
  - For in_vec low bits 00,01,10,11 -> out_vec[3]=0,1,1,0.
  - Latency 6 cycles.
- SR latch: 16=nand(0,17), 17=nand(1,16), passes=2.
  - in=0b10 (S low) -> out_vec[0]=1.
  - Then in=0b11 -> out_vec[0] stays 1 (retained).
  - Then in=0b01 -> out_vec[0]=0.
- num_gates=0 after reset -> done 2 cycles after start, out_vec=0x00.
  - num_passes=0 with 1 gate behaves as passes=1: same latency as the inverter case.
- Reset mid-EVAL (R low during gate 2 of XOR run):
  - Next cycle busy=0, done=0, out_vec=0.
  - Rerun gives correct XOR.
  - Gate memory is intact.
- While busy: start pulse and gate_we to gate 0 -> both ignored.
  - Exactly one done.
  - The next run still uses the original gate 0.

Source files
------------

// File: rtl/nand_netlist_eval.sv
// nand_netlist_eval
//   Sequential evaluator for NAND-only gate netlists. A gate list (input nets
//   a, b and output net y per gate) is held in gate memory. On start the
//   primary inputs are written to nets 0..IN_W-1, then the gates are swept in
//   address order, one gate per cycle, for the requested number of passes.
//   Finally nets OUT_BASE..OUT_BASE+OUT_W-1 are captured on out_vec. Net values
//   persist between runs so latch/flop structures built from NANDs hold state.
//
// Ports
//   C          clock, rising edge
//   R          synchronous active-low reset (clears state, nets, outputs)
//   gate_we    gate memory write enable (honoured in IDLE and DONE only)
//   gate_addr  gate index to write
//   gate_a/b   input nets of the gate being written
//   gate_y     output net of the gate being written
//   start      one-cycle evaluate request (honoured in IDLE only)
//   in_vec     primary input values, sampled with start
//   num_gates  number of gates to evaluate, sampled with start
//   num_passes sweeps over the gate list, 0 treated as 1, sampled with start
//   busy       high in LOAD and EVAL
//   done       one-cycle pulse, out_vec valid
//   out_vec    captured output nets, held until the next done
module nand_netlist_eval #(
  parameter int NET_AW   = 8,
  parameter int GATE_AW  = 8,
  parameter int IN_W     = 8,
  parameter int OUT_W    = 8,
  parameter int OUT_BASE = 16,
  parameter int PASS_W   = 4
) (
  input  logic               C,
  input  logic               R,
  input  logic               gate_we,
  input  logic [GATE_AW-1:0] gate_addr,
  input  logic [NET_AW-1:0]  gate_a,
  input  logic [NET_AW-1:0]  gate_b,
  input  logic [NET_AW-1:0]  gate_y,
  input  logic               start,
  input  logic [IN_W-1:0]    in_vec,
  input  logic [GATE_AW:0]   num_gates,
  input  logic [PASS_W-1:0]  num_passes,
  output logic               busy,
  output logic               done,
  output logic [OUT_W-1:0]   out_vec
);

  localparam int NETS  = 1 << NET_AW;
  localparam int GATES = 1 << GATE_AW;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EVAL, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [NET_AW-1:0]   r_ga [GATES];
  logic [NET_AW-1:0]   r_gb [GATES];
  logic [NET_AW-1:0]   r_gy [GATES];
  logic                r_val [NETS];

  logic [IN_W-1:0]     r_in;
  logic [GATE_AW:0]    r_ngates;
  logic [PASS_W-1:0]   r_passes;
  logic [GATE_AW-1:0]  r_g;
  logic [PASS_W-1:0]   r_p;
  logic                r_done;
  logic [OUT_W-1:0]    r_out;

  logic                w_gate_wr;
  logic                w_last_gate;
  logic                w_last_pass;
  logic [NET_AW-1:0]   w_a;
  logic [NET_AW-1:0]   w_b;
  logic [NET_AW-1:0]   w_y;
  logic                w_nand;
  logic [GATE_AW:0]    w_ngates_m1;
  logic [PASS_W-1:0]   w_passes_m1;

  assign w_gate_wr   = gate_we && (r_state == S_IDLE || r_state == S_DONE);
  assign w_ngates_m1 = r_ngates - (GATE_AW+1)'(1);
  assign w_passes_m1 = r_passes - PASS_W'(1);
  assign w_last_gate = ({1'b0, r_g} == w_ngates_m1);
  assign w_last_pass = (r_p == w_passes_m1);

  // Combinational read of the current gate and its operand nets; a write made
  // by the previous gate is already visible here.
  assign w_a    = r_ga[r_g];
  assign w_b    = r_gb[r_g];
  assign w_y    = r_gy[r_g];
  assign w_nand = ~(r_val[w_a] & r_val[w_b]);

  assign busy    = (r_state == S_LOAD) || (r_state == S_EVAL);
  assign done    = r_done;
  assign out_vec = r_out;

  // Gate memory deliberately survives reset.
  always_ff @(posedge C) begin
    if (w_gate_wr) begin
      r_ga[gate_addr] <= gate_a;
      r_gb[gate_addr] <= gate_b;
      r_gy[gate_addr] <= gate_y;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = (r_ngates == '0) ? S_DONE : S_EVAL;
      S_EVAL: if (w_last_gate && w_last_pass) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (!R) begin
      r_state  <= S_IDLE;
      r_done   <= 1'b0;
      r_out    <= '0;
      r_g      <= '0;
      r_p      <= '0;
      r_in     <= '0;
      r_ngates <= '0;
      r_passes <= PASS_W'(1);
      for (int i = 0; i < NETS; i++) r_val[i] <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // done is registered off DONE so it coincides with the freshly captured out_vec.
      r_done  <= (r_state == S_DONE);

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_in     <= in_vec;
            r_ngates <= num_gates;
            r_passes <= (num_passes == '0) ? PASS_W'(1) : num_passes;
          end
        end
        S_LOAD: begin
          for (int i = 0; i < IN_W; i++) r_val[NET_AW'(i)] <= r_in[i];
          r_g <= '0;
          r_p <= '0;
        end
        S_EVAL: begin
          r_val[w_y] <= w_nand;
          if (w_last_gate) begin
            r_g <= '0;
            if (!w_last_pass) r_p <= r_p + PASS_W'(1);
          end else begin
            r_g <= r_g + GATE_AW'(1);
          end
        end
        S_DONE: begin
          for (int i = 0; i < OUT_W; i++) r_out[i] <= r_val[NET_AW'(OUT_BASE + i)];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nand_netlist_eval.sv
module tb_nand_netlist_eval;

  localparam int NET_AW   = 8;
  localparam int GATE_AW  = 8;
  localparam int IN_W     = 8;
  localparam int OUT_W    = 8;
  localparam int OUT_BASE = 16;
  localparam int PASS_W   = 4;

  logic               C = 1'b0;
  logic               R;
  logic               gate_we;
  logic [GATE_AW-1:0] gate_addr;
  logic [NET_AW-1:0]  gate_a, gate_b, gate_y;
  logic               start;
  logic [IN_W-1:0]    in_vec;
  logic [GATE_AW:0]   num_gates;
  logic [PASS_W-1:0]  num_passes;
  logic               busy, done;
  logic [OUT_W-1:0]   out_vec;

  nand_netlist_eval #(
    .NET_AW(NET_AW), .GATE_AW(GATE_AW), .IN_W(IN_W), .OUT_W(OUT_W),
    .OUT_BASE(OUT_BASE), .PASS_W(PASS_W)
  ) dut (
    .C(C), .R(R), .gate_we(gate_we), .gate_addr(gate_addr),
    .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y),
    .start(start), .in_vec(in_vec), .num_gates(num_gates),
    .num_passes(num_passes), .busy(busy), .done(done), .out_vec(out_vec)
  );

  always #5 C = ~C;

  int cyc = 0;
  always @(posedge C) cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: net file and gate list, evaluated strictly in order.
  logic              m_val [1 << NET_AW];
  logic [NET_AW-1:0] m_ga  [1 << GATE_AW];
  logic [NET_AW-1:0] m_gb  [1 << GATE_AW];
  logic [NET_AW-1:0] m_gy  [1 << GATE_AW];

  typedef struct {
    logic [OUT_W-1:0] out;
    int               lat;
  } exp_t;
  exp_t sbq[$];

  int start_cyc;

  task automatic model_clear();
    for (int i = 0; i < (1 << NET_AW); i++) m_val[i] = 1'b0;
  endtask

  task automatic model_run(input logic [IN_W-1:0] in, input int ng, input int np);
    exp_t e;
    int   p;
    p = (np == 0) ? 1 : np;
    for (int i = 0; i < IN_W; i++) m_val[i] = in[i];
    for (int pp = 0; pp < p; pp++)
      for (int g = 0; g < ng; g++)
        m_val[m_gy[g]] = ~(m_val[m_ga[g]] & m_val[m_gb[g]]);
    for (int i = 0; i < OUT_W; i++) e.out[i] = m_val[OUT_BASE + i];
    e.lat = 2 + ng * p;
    sbq.push_back(e);
  endtask

  task automatic wr_gate(input int addr, input int a, input int b, input int y);
    @(posedge C); #1;
    gate_we = 1'b1; gate_addr = GATE_AW'(addr);
    gate_a = NET_AW'(a); gate_b = NET_AW'(b); gate_y = NET_AW'(y);
    @(posedge C); #1;
    gate_we = 1'b0;
    m_ga[addr] = NET_AW'(a); m_gb[addr] = NET_AW'(b); m_gy[addr] = NET_AW'(y);
  endtask

  task automatic do_reset(input string tag);
    @(posedge C); #1;
    R = 1'b0;
    @(posedge C); #1;
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_out"},  32'(out_vec), 0);
    R = 1'b1;
    model_clear();
  endtask

  // Pulse start; when push is set the model result is queued for collect.
  task automatic kick(input logic [IN_W-1:0] in, input int ng, input int np, input bit push);
    if (push) model_run(in, ng, np);
    @(posedge C); #1;
    start = 1'b1; in_vec = in;
    num_gates = (GATE_AW+1)'(ng); num_passes = PASS_W'(np);
    @(posedge C); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic collect(input string tag, output logic [OUT_W-1:0] got, output int lat);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge C); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    lat = cyc - start_cyc;
    got = out_vec;
    if (!seen) chk({tag, "_done_seen"}, 32'(done), 1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "_out"}, 32'(got), 32'(e.out));
      chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    end
  endtask

  logic [OUT_W-1:0] got;
  int               lat;
  int               ndone;

  initial begin
    R = 1'b0; gate_we = 1'b0; gate_addr = '0; gate_a = '0; gate_b = '0; gate_y = '0;
    start = 1'b0; in_vec = '0; num_gates = '0; num_passes = '0;
    model_clear();
    for (int i = 0; i < (1 << GATE_AW); i++) begin
      m_ga[i] = '0; m_gb[i] = '0; m_gy[i] = '0;
    end

    repeat (2) @(posedge C);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_out",  32'(out_vec), 0);
    R = 1'b1;

    // Inverter
    wr_gate(0, 0, 0, 16);
    kick(8'h01, 1, 1, 1);
    chk("inv_busy", 32'(busy), 1);
    collect("inv1", got, lat);
    chk("inv1_val", 32'(got), 32'h00);
    chk("inv1_lat3", 32'(lat), 3);
    kick(8'h00, 1, 1, 1);
    collect("inv0", got, lat);
    chk("inv0_val", 32'(got), 32'h01);
    kick(8'h01, 1, 0, 1);
    collect("inv_p0", got, lat);
    chk("inv_p0_lat3", 32'(lat), 3);

    // XOR from 4 NANDs
    wr_gate(0, 0, 1, 16);
    wr_gate(1, 0, 16, 17);
    wr_gate(2, 1, 16, 18);
    wr_gate(3, 17, 18, 19);
    for (int v = 0; v < 4; v++) begin
      kick(IN_W'(v), 4, 1, 1);
      collect($sformatf("xor%0d", v), got, lat);
      chk($sformatf("xor%0d_bit", v), 32'(got[3]), 32'(v[0] ^ v[1]));
      chk($sformatf("xor%0d_lat6", v), 32'(lat), 6);
    end

    // SR latch, two passes
    wr_gate(0, 0, 17, 16);
    wr_gate(1, 1, 16, 17);
    kick(8'b10, 2, 2, 1);
    collect("sr_set", got, lat);
    chk("sr_set_q", 32'(got[0]), 1);
    kick(8'b11, 2, 2, 1);
    collect("sr_hold", got, lat);
    chk("sr_hold_q", 32'(got[0]), 1);
    kick(8'b01, 2, 2, 1);
    collect("sr_rst", got, lat);
    chk("sr_rst_q", 32'(got[0]), 0);

    // num_gates = 0 after reset
    do_reset("rst2");
    kick(8'h00, 0, 1, 1);
    collect("zero", got, lat);
    chk("zero_val", 32'(got), 0);
    chk("zero_lat2", 32'(lat), 2);

    // Reset in the middle of an XOR sweep
    wr_gate(0, 0, 1, 16);
    wr_gate(1, 0, 16, 17);
    wr_gate(2, 1, 16, 18);
    wr_gate(3, 17, 18, 19);
    kick(8'h01, 4, 1, 1);
    collect("xor_pre", got, lat);
    kick(8'h03, 4, 1, 0);
    repeat (2) @(posedge C);
    #1;
    R = 1'b0;
    @(posedge C); #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_out",  32'(out_vec), 0);
    R = 1'b1;
    model_clear();
    kick(8'h02, 4, 1, 1);
    collect("xor_post", got, lat);
    chk("xor_post_bit", 32'(got[3]), 1);

    // start and gate write while busy are ignored
    kick(8'h02, 4, 1, 1);
    @(posedge C); #1;
    start = 1'b1; in_vec = 8'h00;
    gate_we = 1'b1; gate_addr = '0; gate_a = 8'd0; gate_b = 8'd0; gate_y = 8'd16;
    @(posedge C); #1;
    start = 1'b0; gate_we = 1'b0;
    collect("busy_run", got, lat);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge C); #1;
      if (done) ndone++;
    end
    chk("busy_extra_done", 32'(ndone), 0);
    kick(8'h01, 4, 1, 1);
    collect("busy_after", got, lat);
    chk("busy_after_bit", 32'(got[3]), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
